// File: rtl/aer_link_arbiter.sv
// aer_link_arbiter: round-robin share of the AER input link between two one-entry slots, with a 4-phase REQ/ACK handshake and ACK timeout
module aer_link_arbiter #(
  parameter int AER_BITS    = 10,
  parameter int ACK_TIMEOUT = 255,
  parameter int TO_BITS     = $clog2(ACK_TIMEOUT + 1)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [AER_BITS-1:0] REQ0_ADDR,
  input  logic                REQ0_VALID,
  output logic                REQ0_READY,
  input  logic [AER_BITS-1:0] REQ1_ADDR,
  input  logic                REQ1_VALID,
  output logic                REQ1_READY,
  output logic [AER_BITS-1:0] AERIN_ADDR,
  output logic                AERIN_REQ,
  input  logic                AERIN_ACK,
  output logic                BUSY,
  output logic                GRANT_ID,
  output logic                DONE,
  output logic                TIMEOUT_ERR,
  input  logic                ERR_CLR
);
  typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} state_t;
  state_t state, state_n;
  logic slot0_full, slot1_full, ack_m, ack_s, last_grant, hs_to, hs_to_n;
  logic [AER_BITS-1:0] slot0_data, slot1_data;
  logic [TO_BITS-1:0] to_cnt, cnt_n;
  logic win, grant, phase_to, req_n, done_n, err_set;
  assign REQ0_READY = !slot0_full;
  assign REQ1_READY = !slot1_full;
  assign BUSY = state != IDLE | slot0_full | slot1_full;
  assign win = slot0_full & slot1_full ? !last_grant : slot1_full;
  assign phase_to = to_cnt == TO_BITS'(ACK_TIMEOUT - 1);
  always_comb begin
    state_n = state;
    cnt_n = to_cnt;
    req_n = AERIN_REQ;
    hs_to_n = hs_to;
    done_n = 1'b0;
    err_set = 1'b0;
    grant = 1'b0;
    case (state)
      IDLE: if (slot0_full | slot1_full) begin
        grant = 1'b1;
        req_n = 1'b1;
        cnt_n = '0;
        hs_to_n = 1'b0;
        state_n = WAIT_HI;
      end
      WAIT_HI: if (ack_s | phase_to) begin
        req_n = 1'b0;
        cnt_n = '0;
        err_set = !ack_s;
        hs_to_n = !ack_s;
        state_n = WAIT_LO;
      end else cnt_n = to_cnt + TO_BITS'(1);
      // a dropped event still drains ACK here but never reports DONE
      WAIT_LO: if (!ack_s | phase_to) begin
        done_n = !ack_s & !hs_to;
        err_set = ack_s;
        state_n = IDLE;
      end else cnt_n = to_cnt + TO_BITS'(1);
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      slot0_full <= 1'b0;
      slot1_full <= 1'b0;
      slot0_data <= '0;
      slot1_data <= '0;
      ack_m <= 1'b0;
      ack_s <= 1'b0;
      last_grant <= 1'b1;
      hs_to <= 1'b0;
      to_cnt <= '0;
      AERIN_ADDR <= '0;
      AERIN_REQ <= 1'b0;
      GRANT_ID <= 1'b0;
      DONE <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      state <= state_n;
      to_cnt <= cnt_n;
      hs_to <= hs_to_n;
      AERIN_REQ <= req_n;
      DONE <= done_n;
      ack_m <= AERIN_ACK;
      ack_s <= ack_m;
      TIMEOUT_ERR <= err_set | (TIMEOUT_ERR & !ERR_CLR);
      slot0_full <= REQ0_VALID & REQ0_READY ? 1'b1 : grant & !win ? 1'b0 : slot0_full;
      slot1_full <= REQ1_VALID & REQ1_READY ? 1'b1 : grant & win ? 1'b0 : slot1_full;
      if (REQ0_VALID & REQ0_READY) slot0_data <= REQ0_ADDR;
      if (REQ1_VALID & REQ1_READY) slot1_data <= REQ1_ADDR;
      if (grant) begin
        AERIN_ADDR <= win ? slot1_data : slot0_data;
        GRANT_ID <= win;
        last_grant <= win;
      end
    end
  end
endmodule
